// File: rtl/note_queue.sv
// Timestamped note FIFO: releases each head entry's lane pattern while game_timer
// equals its timestamp; accounts for merged, rejected, dropped and missed entries.
module note_queue #(
  parameter int DEPTH = 16,
  parameter int TS_W  = 10,
  parameter int PAT_W = 8,
  parameter int CNT_W = 5
) (
  input  logic                  CLOCK50M,
  input  logic                  reset,
  input  logic                  write,
  input  logic [TS_W+PAT_W-1:0] pattern_with_timestamp,
  input  logic [TS_W-1:0]       game_timer,
  output logic [PAT_W-1:0]      pattern,
  output logic                  pattern_valid,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  order_err,
  output logic [7:0]            skipped
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {EMPTY, WAIT, SHOW} state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state_q, state_d;
  logic [TS_W-1:0]  ts_mem  [DEPTH];
  logic [PAT_W-1:0] pat_mem [DEPTH];
  logic [AW-1:0]    rd_q, wr_q, tail_idx;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, full_q, ovf_q, ovf_d, ord_q, ord_d;
  logic [7:0]       skip_q, skip_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             vld_q, vld_d;
  logic             write_q, push_req, pop, store, merge;
  logic [TS_W-1:0]  in_ts, h_ts;
  logic [PAT_W-1:0] in_pat;

  assign in_ts    = pattern_with_timestamp[TS_W+PAT_W-1:PAT_W];
  assign in_pat   = pattern_with_timestamp[PAT_W-1:0];
  assign push_req = write & ~write_q;
  assign tail_idx = wr_q - AW'(1);
  assign h_ts     = ts_mem[rd_q];

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    pat_d   = '0;
    vld_d   = 1'b0;
    skip_d  = skip_q;
    ovf_d   = ovf_q;
    ord_d   = ord_q;
    store   = 1'b0;
    merge   = 1'b0;

    // Head evaluation: stale heads pop, a matching head is shown
    if (count_q != '0) begin
      if (h_ts < game_timer) begin
        pop     = 1'b1;
        state_d = WAIT;
        if (state_q != SHOW) skip_d = sat_inc(skip_q);
      end else if (h_ts == game_timer) begin
        state_d = SHOW;
        pat_d   = pat_mem[rd_q];
        vld_d   = 1'b1;
      end else begin
        state_d = WAIT;
      end
    end

    // Push classification against the last stored entry
    if (push_req) begin
      if (count_q != '0 && in_ts < ts_mem[tail_idx]) begin
        ord_d = 1'b1;
      end else if (count_q != '0 && in_ts == ts_mem[tail_idx]) begin
        merge = 1'b1;
      end else if (count_q == CNT_W'(DEPTH) && !pop) begin
        ovf_d = 1'b1;
      end else begin
        store = 1'b1;
      end
    end

    count_d = count_q + CNT_W'(store) - CNT_W'(pop);
    if (count_d == '0)          state_d = EMPTY;
    else if (state_d == EMPTY)  state_d = WAIT;
  end

  always_ff @(posedge CLOCK50M) begin
    if (reset) begin
      state_q <= EMPTY;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ord_q   <= 1'b0;
      skip_q  <= '0;
      pat_q   <= '0;
      vld_q   <= 1'b0;
      // Tracks write during reset so a level held across reset is not a new edge
      write_q <= write;
    end else begin
      state_q <= state_d;
      if (pop)   rd_q <= rd_q + AW'(1);
      if (store) wr_q <= wr_q + AW'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_W'(DEPTH));
      ovf_q   <= ovf_d;
      ord_q   <= ord_d;
      skip_q  <= skip_d;
      pat_q   <= pat_d;
      vld_q   <= vld_d;
      write_q <= write;
    end
  end

  always_ff @(posedge CLOCK50M) begin
    if (store) begin
      ts_mem[wr_q]  <= in_ts;
      pat_mem[wr_q] <= in_pat;
    end else if (merge) begin
      pat_mem[tail_idx] <= pat_mem[tail_idx] | in_pat;
    end
  end

  assign pattern       = pat_q;
  assign pattern_valid = vld_q;
  assign count         = count_q;
  assign empty         = empty_q;
  assign full          = full_q;
  assign overflow      = ovf_q;
  assign order_err     = ord_q;
  assign skipped       = skip_q;

endmodule

// File: tb/tb_note_queue.sv
// Directed bench for note_queue: timing of release, merge/reject/overflow,
// stale draining, write edge detection and reset behaviour.
module tb_note_queue;

  logic        clk = 1'b0;
  logic        reset, write;
  logic [17:0] pwt;
  logic [9:0]  tm;
  logic [7:0]  pattern;
  logic        pattern_valid;
  logic [4:0]  count;
  logic        empty, full, overflow, order_err;
  logic [7:0]  skipped;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  note_queue dut (
    .CLOCK50M(clk), .reset(reset), .write(write),
    .pattern_with_timestamp(pwt), .game_timer(tm),
    .pattern(pattern), .pattern_valid(pattern_valid), .count(count),
    .empty(empty), .full(full), .overflow(overflow),
    .order_err(order_err), .skipped(skipped)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [9:0] ts, input logic [7:0] pat);
    pwt   = {ts, pat};
    write = 1'b1;
    step();
    write = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    write = 1'b0;
    tm    = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    pwt = '0;
    do_reset();
    chk("rst_pattern", pattern, 0);
    chk("rst_valid", pattern_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ord", order_err, 0);
    chk("rst_skip", skipped, 0);

    // Basic release timing
    tm = 10'd4;
    push(10'd5, 8'h81);
    chk("t1_count", count, 1);
    chk("t1_wait_valid", pattern_valid, 0);
    tm = 10'd5;
    step();
    chk("t1_pattern", pattern, 8'h81);
    chk("t1_valid", pattern_valid, 1);
    tm = 10'd6;
    step();
    chk("t1_pop_pattern", pattern, 0);
    chk("t1_pop_count", count, 0);
    chk("t1_skip", skipped, 0);
    chk("t1_empty", empty, 1);

    // Merge of equal timestamps
    tm = 10'd0;
    push(10'd3, 8'h01);
    push(10'd3, 8'h10);
    chk("t2_count", count, 1);
    tm = 10'd3;
    step();
    chk("t2_pattern", pattern, 8'h11);
    tm = 10'd4;
    step();
    chk("t2_empty", empty, 1);

    // Out-of-order rejection
    push(10'd8, 8'h02);
    push(10'd7, 8'h04);
    chk("t3_order_err", order_err, 1);
    chk("t3_count_rej", count, 1);
    push(10'd9, 8'h08);
    chk("t3_count_acc", count, 2);

    // Overflow and push-with-pop while full
    do_reset();
    chk("t4_rst_ord", order_err, 0);
    for (int i = 10; i < 26; i++) push(10'(i), 8'(i));
    chk("t4_full16", full, 1);
    push(10'd26, 8'h1A);
    chk("t4_overflow", overflow, 1);
    chk("t4_full", full, 1);
    chk("t4_count", count, 16);
    tm    = 10'd11;
    pwt   = {10'd27, 8'h1B};
    write = 1'b1;
    step();
    chk("t4_pp_count", count, 16);
    chk("t4_pp_full", full, 1);
    write = 1'b0;
    step();
    chk("t4_show11", pattern, 8'h0B);
    chk("t4_valid", pattern_valid, 1);
    chk("t4_skip", skipped, 1);
    chk("t4_count2", count, 16);

    // Stale entries drain one per cycle
    do_reset();
    push(10'd2, 8'hFF);
    push(10'd3, 8'hFF);
    push(10'd4, 8'hFF);
    chk("t5_count", count, 3);
    tm = 10'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_drain_count", count, 32'(2 - i));
      chk("t5_drain_pattern", pattern, 0);
    end
    step();
    chk("t5_pattern_after", pattern, 0);
    chk("t5_skip", skipped, 3);
    chk("t5_empty", empty, 1);

    // Level-held write pushes once
    do_reset();
    pwt   = {10'd50, 8'h5A};
    write = 1'b1;
    for (int i = 0; i < 20; i++) step();
    write = 1'b0;
    step();
    chk("t6_one_push", count, 1);
    tm = 10'd50;
    step();
    chk("t6_show", pattern, 8'h5A);

    // Reset while showing, write held across reset
    pwt   = {10'd60, 8'h3C};
    write = 1'b1;
    reset = 1'b1;
    step();
    chk("t6_rst_pattern", pattern, 0);
    chk("t6_rst_valid", pattern_valid, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_empty", empty, 1);
    reset = 1'b0;
    step();
    step();
    step();
    chk("t6_no_push_held", count, 0);
    write = 1'b0;
    step();
    write = 1'b1;
    step();
    chk("t6_repush", count, 1);
    write = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
